serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 23 ++
 rtl/serial_adder_full_adder.sv | 21 ++
 rtl/serial_adder.sv | 127 ++++++++++++
 tb/tb_serial_adder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//     state_t    - FSM state encoding (IDLE/RUN/DONE)
//     cnt_width  - bit-counter width derived from the operand width
//     CNT_W      - counter width for the default 8-bit build
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Counter only has to reach WIDTH-1; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder
//   One-bit combinational full adder used as the serial datapath cell.
//   Ports:
//     A, B  - operand bits
//     Cin   - carry in
//     Sum   - sum bit
//     Cout  - carry out
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    always_comb begin
        Sum  = A ^ B ^ Cin;
        Cout = (A & B) | (A & Cin) | (B & Cin);
    end

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: operands are captured on Start, then processed one
//   bit per clock (LSB first) through a single full_adder cell. The result
//   appears on Sum/Carry together with a one-cycle Done pulse.
//   Optional subtract support is built when SERIAL_ADDER_SUB_EN is defined.
//   Parameters:
//     WIDTH  - operand/result width (2..32)
//   Ports:
//     Clk    - rising-edge clock
//     Rst    - asynchronous active-high reset
//     Start  - begin an operation (sampled in IDLE only)
//     A, B   - operands, captured on the accepting edge
//     Mode   - 0 = A+B, 1 = A-B (only with SERIAL_ADDER_SUB_EN)
//     Sum    - registered result of the last completed operation
//     Carry  - registered carry-out (subtract: 1 = no borrow)
//     Busy   - high while the operation is running
//     Done   - one-cycle pulse when a new result is loaded
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Mode,
`endif
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] r_sr;     // sum bits collected so far
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             fa_b;
    logic             fa_s;
    logic             fa_co;
    logic             init_cy;
    logic [WIDTH-1:0] r_nxt;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub;
    // Subtract as A + ~B + 1: invert B bit-by-bit, seed carry with 1.
    assign fa_b    = b_sr[0] ^ sub;
    assign init_cy = Mode;
`else
    assign fa_b    = b_sr[0];
    assign init_cy = 1'b0;
`endif

    full_adder u_fa (
        .A    (a_sr[0]),
        .B    (fa_b),
        .Cin  (cy),
        .Sum  (fa_s),
        .Cout (fa_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the word is aligned.
    assign r_nxt = {fa_s, r_sr};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            cnt   <= '0;
            cy    <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub   <= 1'b0;
`endif
            Sum   <= '0;
            Carry <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        cnt   <= '0;
                        cy    <= init_cy;
`ifdef SERIAL_ADDER_SUB_EN
                        sub   <= Mode;
`endif
                        Busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= r_nxt[WIDTH-1:1];
                    cy   <= fa_co;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        Sum   <= r_nxt;
                        Carry <= fa_co;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed checks of serial_adder: an 8-bit instance for timing, control
//   and reset behaviour, and a 4-bit instance swept over all operand pairs.
//   Subtract vectors are included when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic [7:0] a8, b8, sum8;
    logic [3:0] a4, b4, sum4;
    logic       carry8, busy8, done8;
    logic       carry4, busy4, done4;
`ifdef SERIAL_ADDER_SUB_EN
    logic       mode8, mode4;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .Clk   (clk),
        .Rst   (rst),
        .Start (start8),
        .A     (a8),
        .B     (b8),
`ifdef SERIAL_ADDER_SUB_EN
        .Mode  (mode8),
`endif
        .Sum   (sum8),
        .Carry (carry8),
        .Busy  (busy8),
        .Done  (done8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .Clk   (clk),
        .Rst   (rst),
        .Start (start4),
        .A     (a4),
        .B     (b4),
`ifdef SERIAL_ADDER_SUB_EN
        .Mode  (mode4),
`endif
        .Sum   (sum4),
        .Carry (carry4),
        .Busy  (busy4),
        .Done  (done4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts negedges until Done is seen (bounded); n = -1 on timeout.
    task automatic wait_done8(output int n);
        n = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (done8) begin
                n = i;
                break;
            end
        end
    endtask

    // One 8-bit operation started from IDLE. Operands are scrambled right
    // after the accepting edge; Sum must hold its old value until Done.
    // edges: negedge index of Done counting the accepting edge as the first.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_s, input logic exp_c,
                       output int edges, output int busy_cnt);
        logic [7:0] prev;
        logic       hold_ok;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        prev = sum8;
        hold_ok = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = ~a; b8 = a ^ b;
        edges = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (busy8) busy_cnt++;
            if (done8) begin
                edges = i;
                break;
            end
            if (sum8 !== prev) hold_ok = 1'b0;
        end
        chk({tag, "_done_seen"}, 64'(edges > 0), 64'd1);
        chk({tag, "_sum"}, 64'(sum8), 64'(exp_s));
        chk({tag, "_carry"}, 64'(carry8), 64'(exp_c));
        chk({tag, "_sum_hold"}, 64'(hold_ok), 64'd1);
    endtask

    initial begin
        int e, bc, n, cnt_done, cnt_busy;
        logic [4:0] ref4;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
`ifdef SERIAL_ADDER_SUB_EN
        mode8 = 1'b0; mode4 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sum", 64'(sum8), 64'd0);
        chk("rst_carry", 64'(carry8), 64'd0);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);

        // 0x0F + 0x01: Busy 8 cycles, Done on 9th edge counting accept
        op8("v0f01", 8'h0F, 8'h01, 8'h10, 1'b0, e, bc);
        chk("v0f01_done_edge", 64'(e), 64'd9);
        chk("v0f01_busy_cycles", 64'(bc), 64'd8);
        @(negedge clk);
        chk("v0f01_done_pulse_width", 64'(done8), 64'd0);

        op8("vff01", 8'hFF, 8'h01, 8'h00, 1'b1, e, bc);
        op8("vaa55", 8'hAA, 8'h55, 8'hFF, 1'b0, e, bc);
        op8("vc864", 8'hC8, 8'h64, 8'h2C, 1'b1, e, bc);
        op8("v7f01", 8'h7F, 8'h01, 8'h80, 1'b0, e, bc);

        // Back-to-back with Start held high
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        wait_done8(n);
        chk("b2b_first_seen", 64'(n > 0), 64'd1);
        chk("b2b_first_sum", 64'(sum8), 64'h00);
        chk("b2b_first_carry", 64'(carry8), 64'd1);
        a8 = 8'h80; b8 = 8'h80;
        wait_done8(n);
        start8 = 1'b0;
        chk("b2b_spacing", 64'(n), 64'd10);
        chk("b2b_second_sum", 64'(sum8), 64'h00);
        chk("b2b_second_carry", 64'(carry8), 64'd1);
        repeat (2) @(negedge clk);
        chk("b2b_idle_after", 64'(busy8), 64'd0);

        // Start pulsed mid-RUN must be ignored
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hAA; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(n);
        chk("ign_done_seen", 64'(n > 0), 64'd1);
        chk("ign_sum", 64'(sum8), 64'h02);
        chk("ign_carry", 64'(carry8), 64'd0);
        cnt_done = 0; cnt_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8) cnt_done++;
            if (busy8) cnt_busy++;
        end
        chk("ign_extra_done", 64'(cnt_done), 64'd0);
        chk("ign_extra_busy", 64'(cnt_busy), 64'd0);

        // Reset on the 4th RUN cycle of 0x33 + 0x11
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 64'(busy8), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_sum", 64'(sum8), 64'h00);
        chk("abort_carry", 64'(carry8), 64'd0);
        chk("abort_busy", 64'(busy8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) cnt_done++;
        end
        chk("abort_no_done", 64'(cnt_done), 64'd0);
        op8("after_abort", 8'h33, 8'h11, 8'h44, 1'b0, e, bc);

`ifdef SERIAL_ADDER_SUB_EN
        mode8 = 1'b1;
        op8("sub0507", 8'h05, 8'h07, 8'hFE, 1'b0, e, bc);
        op8("sub0705", 8'h07, 8'h05, 8'h02, 1'b1, e, bc);
        mode8 = 1'b0;
        op8("add_after_sub", 8'h05, 8'h07, 8'h0C, 1'b0, e, bc);
`endif

        // Exhaustive 4-bit sweep against {Carry,Sum} = A + B
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                a4 = 4'(i); b4 = 4'(j); start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                a4 = ~a4;
                n = -1;
                for (int k = 1; k <= 20; k++) begin
                    if (done4) begin
                        n = k;
                        break;
                    end
                    @(negedge clk);
                end
                ref4 = 5'(i) + 5'(j);
                if (n < 0) chk("sweep_timeout", 64'd0, 64'd1);
                else chk($sformatf("sweep_%0h_%0h", i, j), 64'({carry4, sum4}), 64'(ref4));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
